sram_responder: RTL
===================

Name: sram_responder

Overview:
- Clocked behavioural/synthesizable responder for the 16-bit SRAM interface driven by the SLC-3 top level.
- Decodes the active-low CE/OE/WE/UB/LB strobes and ADDR, stores words in an internal array and drives the shared Data bus on reads.
- Serves as the memory end of the bus in simulation benches and in on-chip memory builds.

Parameters:
- DEPTH, 1024, number of 16-bit words implemented; valid addresses are 0..DEPTH-1.
- READ_LATENCY, 2, Clk edges from the first sampled read until Data is driven; range 1..7.
- INIT_MODE, 0, post-reset fill: 0 = all words 16'h0000; 1 = each word equals its address[15:0].

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- CE  in  1  chip enable, active low
- UB  in  1  upper byte (Data[15:8]) enable, active low
- LB  in  1  lower byte (Data[7:0]) enable, active low
- OE  in  1  output enable, active low
- WE  in  1  write enable, active low
- ADDR  in  20  word address
- Data  inout  16  bidirectional data bus
- init_done  out  1  high once the post-reset fill has completed
- access_err  out  1  one-cycle pulse on an out-of-range or illegal access

Behaviour:
- Interface: one clock (Clk); reset is synchronous and active-high (Reset). All strobes, ADDR and Data are sampled on the rising Clk edge.
- Reset values: state=INIT, fill counter=0, init_done=0, access_err=0, Data=high-Z.
- A Reset asserted mid-operation aborts any access and restarts INIT.
- States:
  - INIT: writes the INIT_MODE pattern to word[cnt], one word per cycle, then cnt++. After DEPTH cycles, go to IDLE and set init_done=1. All bus accesses are ignored and Data stays high-Z while in INIT.
  - IDLE:
    - Write, sampled CE=0 and WE=0: for word[ADDR], lane [15:8] is written when UB=0 and lane [7:0] is written when LB=0. The write completes that edge and the state stays IDLE.
    - Read, sampled CE=0, WE=1, OE=0: latch ADDR, load the latency counter with READ_LATENCY-1, go to READ_WAIT (to READ_DRIVE directly if READ_LATENCY=1).
  - READ_WAIT: decrement the counter; go to READ_DRIVE when it reaches 0.
  - READ_DRIVE: drive Data from word[latched ADDR]. A lane is driven only while its UB/LB is 0; disabled lanes are 8'hZZ.
- Exits from READ_WAIT/READ_DRIVE:
  - CE, OE or WE deasserting returns the block to IDLE; Data goes high-Z on that same edge.
  - An ADDR change restarts READ_WAIT with the new address.
- WE has priority over OE. With WE=0 the responder never drives Data, even if OE=0, and a write occurs.
- ADDR >= DEPTH:
  - A write is discarded and access_err pulses.
  - A read drives 16'h0000 after the normal latency and access_err pulses once at entry.
- CE=1 means no access regardless of the other strobes.
- A write with UB=LB=1 stores nothing and is not an error.
- Back-to-back writes on consecutive edges are all accepted.
- A read-after-write to the same address returns the new data.
- Data is driven only in READ_DRIVE; there is no bus contention otherwise.

Optional Feature:
- Macro SRAM_WRITE_PROTECT_EN. When defined, a localparam PROTECT_LIMIT (default 16'h0100) is added.
- Writes to ADDR < PROTECT_LIMIT are discarded and pulse access_err; reads are unaffected.
- When undefined, all in-range addresses are writable and no protect logic exists.

Decomposition:
- Package sram_pkg holds:
  - typedef sram_addr_t (logic [19:0]) and sram_data_t (logic [15:0]);
  - enum sram_state_t {INIT, IDLE, READ_WAIT, READ_DRIVE};
  - constant PROTECT_LIMIT.
- Sub-module sram_lane_merge: combinational byte-lane merge used for write masking (old word, new Data, UB/LB -> stored word) and for per-lane tristate enables.

Test Plan:
- INIT_MODE=1, pulse Reset 1 cycle -> init_done rises exactly 1024 cycles later; a read of 16'h0005 returns 16'h0005 two edges after the read is sampled.
- Write 16'hBEEF to 16'h0010 with UB=LB=0, then a write of 16'h1234 with UB=1, LB=0 -> a read returns 16'hBE34.
- Read with UB=0, LB=1 -> Data[15:8] is driven, Data[7:0] is Z; deasserting OE -> the bus is fully Z on the same edge.
- During a read, ADDR changes from 16'h0020 to 16'h0021 before the latency expires -> no data for 0x20 is driven; 0x21's data appears 2 edges after the change.
- ADDR=20'h00400 (>= DEPTH): write then read -> access_err pulses each time, the read returns 16'h0000, and no in-range word changes.
- Assert Reset during READ_DRIVE -> Data is Z on the next edge, init_done=0, and a prior write of 16'hBEEF reads back as the INIT pattern after the fill.
- With SRAM_WRITE_PROTECT_EN: write to 16'h0050 -> access_err pulses and the word is unchanged.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg: shared types for the SRAM responder.
//   sram_addr_t  - 20-bit word address as seen on ADDR
//   sram_data_t  - 16-bit data word
//   sram_state_t - responder FSM states
// Build option: define SRAM_WRITE_PROTECT_EN to add PROTECT_LIMIT (low write-protected window).
package sram_pkg;

    typedef logic [19:0] sram_addr_t;
    typedef logic [15:0] sram_data_t;

    typedef enum logic [1:0] {
        INIT       = 2'd0,
        IDLE       = 2'd1,
        READ_WAIT  = 2'd2,
        READ_DRIVE = 2'd3
    } sram_state_t;

`ifdef SRAM_WRITE_PROTECT_EN
    // Words below this address reject writes.
    localparam sram_data_t PROTECT_LIMIT = 16'h0100;
`endif

endpackage

// File: rtl/sram_lane_merge.sv
// sram_lane_merge: combinational byte-lane merge for the SRAM responder.
//   old_i     - word currently stored
//   new_i     - word sampled from the data bus
//   ub_ni     - upper byte enable, active low
//   lb_ni     - lower byte enable, active low
//   merged_o  - word to store: enabled lanes from new_i, others from old_i
//   lane_en_o - per-lane enables {upper, lower}, also used as tristate enables
module sram_lane_merge
    import sram_pkg::*;
(
    input  sram_data_t old_i,
    input  sram_data_t new_i,
    input  logic       ub_ni,
    input  logic       lb_ni,
    output sram_data_t merged_o,
    output logic [1:0] lane_en_o
);

    assign lane_en_o = {~ub_ni, ~lb_ni};

    assign merged_o = {lane_en_o[1] ? new_i[15:8] : old_i[15:8],
                       lane_en_o[0] ? new_i[7:0]  : old_i[7:0]};

endmodule

// File: rtl/sram_responder.sv
// sram_responder: 16-bit asynchronous-style SRAM responder with a clocked access model.
//   Clk        - system clock
//   Reset      - synchronous, active-high reset; restarts the post-reset fill
//   CE/UB/LB/OE/WE - active-low chip/lane/output/write strobes, sampled on rising Clk
//   ADDR       - word address
//   Data       - bidirectional data bus, driven only while a read is being served
//   init_done  - high once the post-reset fill has finished
//   access_err - one-cycle pulse on an out-of-range (or protected) access
// Build option: SRAM_WRITE_PROTECT_EN rejects writes below PROTECT_LIMIT.
module sram_responder
    import sram_pkg::*;
#(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned INIT_MODE    = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CE,
    input  logic        UB,
    input  logic        LB,
    input  logic        OE,
    input  logic        WE,
    input  logic [19:0] ADDR,
    inout  wire  [15:0] Data,
    output logic        init_done,
    output logic        access_err
);

    localparam int unsigned IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]  LatLoad = 3'(READ_LATENCY - 1);

    sram_state_t     state_q, state_d;
    logic [IdxW-1:0] fill_q, fill_d;
    sram_addr_t      raddr_q, raddr_d;
    logic [2:0]      lat_q, lat_d;
    logic            init_done_q, init_done_d;
    logic            err_q, err_d;

    sram_data_t      mem_q [DEPTH];
    logic            mem_we;
    logic [IdxW-1:0] mem_idx;
    sram_data_t      mem_wdata;

    logic            wr_req, rd_req, addr_ok, raddr_ok, wr_protected;
    sram_data_t      merged, rd_word;
    logic [1:0]      lane_en;
    logic            drive_hi, drive_lo;

    // WE wins over OE: any cycle with WE low is a write, never a read.
    assign wr_req   = ~CE & ~WE;
    assign rd_req   = ~CE & WE & ~OE;
    assign addr_ok  = 32'(ADDR) < DEPTH;
    assign raddr_ok = 32'(raddr_q) < DEPTH;

`ifdef SRAM_WRITE_PROTECT_EN
    assign wr_protected = ADDR < {4'b0000, PROTECT_LIMIT};
`else
    assign wr_protected = 1'b0;
`endif

    sram_lane_merge u_lane_merge (
        .old_i     (mem_q[ADDR[IdxW-1:0]]),
        .new_i     (Data),
        .ub_ni     (UB),
        .lb_ni     (LB),
        .merged_o  (merged),
        .lane_en_o (lane_en)
    );

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        raddr_d     = raddr_q;
        lat_d       = lat_q;
        init_done_d = init_done_q;
        err_d       = 1'b0;
        mem_we      = 1'b0;
        mem_idx     = ADDR[IdxW-1:0];
        mem_wdata   = merged;

        case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_idx   = fill_q;
                mem_wdata = (INIT_MODE == 1) ? 16'(fill_q) : 16'h0000;
                fill_d    = fill_q + IdxW'(1);
                if (fill_q == IdxW'(DEPTH - 1)) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end
            end
            default: begin
                if (wr_req) begin
                    state_d = IDLE;
                    if (!addr_ok || wr_protected) begin
                        err_d = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                    end
                end else if (rd_req) begin
                    // A fresh read, or an address change mid-read, restarts the latency.
                    if (state_q == IDLE || ADDR != raddr_q) begin
                        raddr_d = ADDR;
                        lat_d   = LatLoad;
                        err_d   = ~addr_ok;
                        state_d = (READ_LATENCY <= 1) ? READ_DRIVE : READ_WAIT;
                    end else if (state_q == READ_WAIT) begin
                        lat_d = lat_q - 3'd1;
                        if (lat_q == 3'd1) begin
                            state_d = READ_DRIVE;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= INIT;
            fill_q      <= '0;
            raddr_q     <= '0;
            lat_q       <= '0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            raddr_q     <= raddr_d;
            lat_q       <= lat_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset && mem_we) begin
            mem_q[mem_idx] <= mem_wdata;
        end
    end

    // Out-of-range reads return zero rather than an aliased word.
    assign rd_word  = raddr_ok ? mem_q[raddr_q[IdxW-1:0]] : 16'h0000;
    assign drive_hi = (state_q == READ_DRIVE) && lane_en[1];
    assign drive_lo = (state_q == READ_DRIVE) && lane_en[0];

    assign Data[15:8] = drive_hi ? rd_word[15:8] : 8'hzz;
    assign Data[7:0]  = drive_lo ? rd_word[7:0]  : 8'hzz;

    assign init_done  = init_done_q;
    assign access_err = err_q;

endmodule
